// File: rtl/bp_io_scratch_responder.sv
// bp_io_scratch_responder
//   Target end of the BedRock io_cmd/io_resp channel. Serves uncached
//   reads/writes from a dword scratch RAM, captures putchar stores into a
//   character FIFO and returns exactly one response per command, with one
//   command outstanding at a time.
//
//   Message layout (LSB first):
//     [3:0]                      msg_type (uc_rd = 2, uc_wr = 3)
//     [7:4]                      subop
//     [8 +: paddr_width_p]       addr
//     [8+paddr_width_p +: 3]     size (bytes = 1 << size)
//     [11+paddr_width_p +: 16]   payload
//     [msg_width_lp-1 -: 64]     data dword
//
//   Optional macro BP_IO_SCRATCH_RESPONDER_TRACE_EN: when defined, adds a
//   simulation-only trace line per accepted command and per FIFO pop.
module bp_io_scratch_responder #(
    parameter int          paddr_width_p       = 40,
    parameter int          scratch_els_p       = 64,
    parameter logic [63:0] scratch_base_addr_p = 64'h0000_0000_0011_0000,
    parameter logic [63:0] putchar_addr_p      = 64'h0000_0000_0010_1000,
    parameter int          char_fifo_els_p     = 8,
    localparam int         hdr_width_lp        = paddr_width_p + 27,
    localparam int         msg_width_lp        = hdr_width_lp + 64
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [msg_width_lp-1:0] io_cmd_i,
    input  logic                    io_cmd_v_i,
    output logic                    io_cmd_ready_and_o,
    output logic [msg_width_lp-1:0] io_resp_o,
    output logic                    io_resp_v_o,
    input  logic                    io_resp_yumi_i,
    output logic [7:0]              char_o,
    output logic                    char_v_o,
    input  logic                    char_yumi_i,
    output logic                    error_o,
    output logic [15:0]             cmd_count_o
);
    localparam int          idx_width_lp   = $clog2(scratch_els_p);
    localparam int          ptr_width_lp   = $clog2(char_fifo_els_p);
    localparam logic [3:0]  uc_rd_lp       = 4'd2;
    localparam logic [3:0]  uc_wr_lp       = 4'd3;
    localparam logic [63:0] scratch_end_lp = scratch_base_addr_p + 64'(8 * scratch_els_p);

    typedef enum logic {e_ready, e_resp} state_e;

    state_e                  state_q, state_d;
    logic [hdr_width_lp-1:0] resp_hdr_q, resp_hdr_d;
    logic                    rd_hit_q, rd_hit_d;
    logic [2:0]              rd_off_q, rd_off_d;
    logic [1:0]              rd_size_q, rd_size_d;
    logic                    error_q, error_d;
    logic [15:0]             cmd_count_q, cmd_count_d;
    logic [ptr_width_lp:0]   wptr_q, wptr_d, rptr_q, rptr_d;

    logic [63:0]             scratch_mem [scratch_els_p];
    logic [63:0]             ram_rdata_q;
    logic [7:0]              char_mem [char_fifo_els_p];

    // Command field decode
    logic [hdr_width_lp-1:0]  cmd_hdr;
    logic [63:0]              cmd_data, cmd_wdata, cmd_addr64;
    logic [3:0]               cmd_type, cmd_bytes;
    logic [paddr_width_p-1:0] cmd_addr;
    logic [2:0]               cmd_size, cmd_off;
    logic [7:0]               cmd_byte_mask;
    logic [idx_width_lp-1:0]  cmd_idx;
    logic cmd_misaligned, scratch_hit, putchar_hit, is_rd, is_wr, cmd_err;
    logic cmd_accept, scratch_wr, scratch_rd, char_push, char_pop, fifo_full;

    assign cmd_hdr    = io_cmd_i[hdr_width_lp-1:0];
    assign cmd_data   = io_cmd_i[msg_width_lp-1 -: 64];
    assign cmd_type   = cmd_hdr[3:0];
    assign cmd_addr   = cmd_hdr[8 +: paddr_width_p];
    assign cmd_size   = cmd_hdr[8+paddr_width_p +: 3];
    assign cmd_off    = cmd_addr[2:0];
    assign cmd_idx    = cmd_addr[3 +: idx_width_lp];
    assign cmd_addr64 = {{(64-paddr_width_p){1'b0}}, cmd_addr};

    // Classify the command: alignment, address window, and resulting error
    always_comb begin
        cmd_bytes      = 4'd1 << cmd_size[1:0];
        // Sizes above a dword cannot fit in one dword lane and count as misaligned
        cmd_misaligned = cmd_size[2] | (({1'b0, cmd_off} + cmd_bytes) > 4'd8);
        cmd_byte_mask  = 8'((16'd1 << cmd_bytes) - 16'd1) << cmd_off;
        cmd_wdata      = cmd_data << {cmd_off, 3'b000};
        scratch_hit    = (cmd_addr64 >= scratch_base_addr_p) && (cmd_addr64 < scratch_end_lp);
        putchar_hit    = (cmd_addr64 == putchar_addr_p);
        is_rd          = (cmd_type == uc_rd_lp);
        is_wr          = (cmd_type == uc_wr_lp);
        cmd_err        = cmd_misaligned | ~((is_rd | is_wr) & (scratch_hit | putchar_hit));
    end

    assign fifo_full  = (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp])
                      && (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0]);
    assign io_cmd_ready_and_o = (state_q == e_ready) & ~fifo_full;
    assign cmd_accept = io_cmd_v_i & io_cmd_ready_and_o;
    assign scratch_wr = cmd_accept & ~cmd_misaligned & is_wr & scratch_hit;
    assign scratch_rd = cmd_accept & ~cmd_misaligned & is_rd & scratch_hit;
    assign char_push  = cmd_accept & ~cmd_misaligned & is_wr & putchar_hit;
    assign char_v_o   = (wptr_q != rptr_q);
    assign char_pop   = char_yumi_i & char_v_o;

    // Next-state: response capture, error/counter updates, FIFO pointers
    always_comb begin
        state_d     = state_q;
        resp_hdr_d  = resp_hdr_q;
        rd_hit_d    = rd_hit_q;
        rd_off_d    = rd_off_q;
        rd_size_d   = rd_size_q;
        error_d     = error_q;
        cmd_count_d = cmd_count_q;
        wptr_d      = wptr_q + (ptr_width_lp+1)'(char_push);
        rptr_d      = rptr_q + (ptr_width_lp+1)'(char_pop);
        case (state_q)
            e_ready: begin
                if (cmd_accept) begin
                    state_d     = e_resp;
                    resp_hdr_d  = cmd_hdr;
                    rd_hit_d    = scratch_rd;
                    rd_off_d    = cmd_off;
                    rd_size_d   = cmd_size[1:0];
                    cmd_count_d = cmd_count_q + 16'd1;
                    error_d     = error_q | cmd_err;
                end
            end
            e_resp: begin
                if (io_resp_yumi_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    // Control state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_ready;
            resp_hdr_q  <= '0;
            rd_hit_q    <= 1'b0;
            rd_off_q    <= 3'd0;
            rd_size_q   <= 2'd0;
            error_q     <= 1'b0;
            cmd_count_q <= 16'd0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            resp_hdr_q  <= resp_hdr_d;
            rd_hit_q    <= rd_hit_d;
            rd_off_q    <= rd_off_d;
            rd_size_q   <= rd_size_d;
            error_q     <= error_d;
            cmd_count_q <= cmd_count_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
        end
    end

    // Scratch RAM: byte-enabled write, registered read captured at accept
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 8; b++) begin
            if (scratch_wr && cmd_byte_mask[b]) begin
                scratch_mem[cmd_idx][8*b +: 8] <= cmd_wdata[8*b +: 8];
            end
        end
        if (scratch_rd) begin
            ram_rdata_q <= scratch_mem[cmd_idx];
        end
    end

    // Character FIFO storage
    always_ff @(posedge clk_i) begin
        if (char_push) begin
            char_mem[wptr_q[ptr_width_lp-1:0]] <= cmd_data[7:0];
        end
    end

    assign char_o = char_mem[rptr_q[ptr_width_lp-1:0]];

    // Read data alignment: shift the captured dword down and keep size bytes
    logic [63:0] rd_shift, resp_data;
    logic [3:0]  rd_bytes;
    assign rd_shift = ram_rdata_q >> {rd_off_q, 3'b000};
    assign rd_bytes = 4'd1 << rd_size_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rd_lane
        assign resp_data[8*gi +: 8] = (rd_hit_q && (4'(gi) < rd_bytes)) ? rd_shift[8*gi +: 8] : 8'h00;
    end

    assign io_resp_o   = {resp_data, resp_hdr_q};
    assign io_resp_v_o = (state_q == e_resp);
    assign error_o     = error_q;
    assign cmd_count_o = cmd_count_q;

`ifdef BP_IO_SCRATCH_RESPONDER_TRACE_EN
    logic [63:0] trace_cycle_q;

    // Simulation trace of accepted commands and FIFO pops
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            trace_cycle_q <= 64'd0;
        end else begin
            trace_cycle_q <= trace_cycle_q + 64'd1;
            if (cmd_accept) begin
                $display("[%0d] io_cmd type=%0d addr=%h size=%0d data=%h",
                         trace_cycle_q, cmd_type, cmd_addr, cmd_size, cmd_data);
            end
            if (char_pop) begin
                $display("[%0d] putchar pop %h", trace_cycle_q, char_o);
            end
        end
    end
`else
    // No trace logic in this build.
`endif

endmodule
